mod12_count_checker: RTL and testbench

- In-RTL checker at the read end of the mod-12 up/down counter interface.
- Samples the counter's control inputs (load, mode, data_in) and its data_out every cycle, predicts the next count and flags mismatches.
- Accumulates error and wrap statistics; captures the first failing pair.
- Sits beside the counter in the top level; runs standalone in silicon or alongside the class-based bench.

---
 rtl/mod12_count_checker.sv | 206 ++++++++++++++++++++
 tb/tb_mod12_count_checker.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod12_count_checker.sv
// mod12_count_checker
// Watches the control inputs and data_out of a mod-MOD up/down counter,
// predicts each next count from the previous cycle's observation and flags
// mismatches and out-of-range values. Keeps saturating error and wrap
// statistics and captures the first failing expected/actual pair.
//
// Handshake: there is no valid/ready pair. Every cycle with obs_en=1 is one
// observation. Every output is registered and reflects the sample taken on
// the previous rising edge of clock.
//
// state_dbg exposes the FSM state (0 = IDLE, 1 = SYNC, 2 = CHECK).
module mod12_count_checker #(
  parameter int CNT_W  = 4,
  parameter int MOD    = 12,
  parameter int ERR_W  = 8,
  parameter int WRAP_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              obs_en,
  input  logic              load,
  input  logic              mode,
  input  logic [CNT_W-1:0]  data_in,
  input  logic [CNT_W-1:0]  count_in,
  output logic              checking,
  output logic              mismatch,
  output logic              range_err,
  output logic              err_sticky,
  output logic [ERR_W-1:0]  error_cnt,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [CNT_W-1:0]  first_exp,
  output logic [CNT_W-1:0]  first_act,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2
  } state_t;

  // One bit wider than a count so MOD itself is representable.
  localparam logic [CNT_W:0]    MOD_V    = (CNT_W+1)'(MOD);
  localparam logic [CNT_W-1:0]  TOP_V    = CNT_W'(MOD - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ERR_W-1:0]  ERR_ONE  = ERR_W'(1);
  localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);

  state_t              state_q, state_d;
  logic                load_q, load_d;
  logic                mode_q, mode_d;
  logic [CNT_W-1:0]    data_q, data_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                checking_q, checking_d;
  logic                mismatch_q, mismatch_d;
  logic                range_q, range_d;
  logic                sticky_q, sticky_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [WRAP_W-1:0]   wrap_q, wrap_d;
  logic [CNT_W-1:0]    fexp_q, fexp_d;
  logic [CNT_W-1:0]    fact_q, fact_d;

  logic [CNT_W-1:0]    pred;
  logic                in_range;
  logic                illegal_load;
  logic                is_wrap;
  logic                fail;

  // Prediction of this cycle's count from last cycle's captured controls and count.
  always_comb begin
    if (load_q) begin
      pred = data_q;
    end else if (mode_q) begin
      pred = (count_q == TOP_V) ? '0 : count_q + CNT_ONE;
    end else begin
      pred = (count_q == '0) ? TOP_V : count_q - CNT_ONE;
    end
  end

  // Classification of the current sample and of the captured load.
  always_comb begin
    in_range     = ({1'b0, count_in} < MOD_V);
    illegal_load = load_q && ({1'b0, data_q} >= MOD_V);
    is_wrap      = !load_q &&
                   (( mode_q && (count_q == TOP_V) && (count_in == '0)) ||
                    (!mode_q && (count_q == '0)    && (count_in == TOP_V)));
  end

  // Next-state, statistics and first-failure capture.
  always_comb begin
    state_d    = state_q;
    load_d     = load_q;
    mode_d     = mode_q;
    data_d     = data_q;
    count_d    = count_q;
    mismatch_d = 1'b0;
    range_d    = 1'b0;
    sticky_d   = sticky_q;
    err_d      = err_q;
    wrap_d     = wrap_q;
    fexp_d     = fexp_q;
    fact_d     = fact_q;
    fail       = 1'b0;

    if (!obs_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SYNC;
        end
        SYNC: begin
          load_d  = load;
          mode_d  = mode;
          data_d  = data_in;
          count_d = count_in;
          // No prediction exists yet: flag the illegal value but do not
          // count it as a failure.
          if (in_range) begin
            state_d = CHECK;
          end else begin
            range_d  = 1'b1;
            sticky_d = 1'b1;
          end
        end
        CHECK: begin
          load_d  = load;
          mode_d  = mode;
          data_d  = data_in;
          count_d = count_in;
          if (illegal_load) begin
            // Loaded value was out of range: nothing to predict, resync.
            state_d = SYNC;
          end else if (!in_range) begin
            range_d = 1'b1;
            fail    = 1'b1;
            state_d = SYNC;
          end else if (count_in != pred) begin
            mismatch_d = 1'b1;
            fail       = 1'b1;
          end else if (is_wrap) begin
            if (wrap_q != '1) wrap_d = wrap_q + WRAP_ONE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (fail) begin
      sticky_d = 1'b1;
      if (err_q != '1) err_d = err_q + ERR_ONE;
      if (!sticky_q) begin
        fexp_d = pred;
        fact_d = count_in;
      end
    end

    checking_d = (state_d == CHECK);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      load_q     <= 1'b0;
      mode_q     <= 1'b0;
      data_q     <= '0;
      count_q    <= '0;
      checking_q <= 1'b0;
      mismatch_q <= 1'b0;
      range_q    <= 1'b0;
      sticky_q   <= 1'b0;
      err_q      <= '0;
      wrap_q     <= '0;
      fexp_q     <= '0;
      fact_q     <= '0;
    end else begin
      state_q    <= state_d;
      load_q     <= load_d;
      mode_q     <= mode_d;
      data_q     <= data_d;
      count_q    <= count_d;
      checking_q <= checking_d;
      mismatch_q <= mismatch_d;
      range_q    <= range_d;
      sticky_q   <= sticky_d;
      err_q      <= err_d;
      wrap_q     <= wrap_d;
      fexp_q     <= fexp_d;
      fact_q     <= fact_d;
    end
  end

  assign checking   = checking_q;
  assign mismatch   = mismatch_q;
  assign range_err  = range_q;
  assign err_sticky = sticky_q;
  assign error_cnt  = err_q;
  assign wrap_cnt   = wrap_q;
  assign first_exp  = fexp_q;
  assign first_act  = fact_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_mod12_count_checker.sv
// Testbench for mod12_count_checker: directed scenarios followed by random
// traffic from a reference counter with injected glitches, scored against
// a behavioural model through an expected-response queue.
module tb_mod12_count_checker;

  localparam int CNT_W  = 4;
  localparam int MOD    = 12;
  localparam int ERR_W  = 8;
  localparam int WRAP_W = 16;
  localparam int ERR_MAX  = (1 << ERR_W) - 1;
  localparam int WRAP_MAX = (1 << WRAP_W) - 1;
  localparam int P_IDLE = 0, P_SYNC = 1, P_CHECK = 2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset;
  logic              obs_en;
  logic              load;
  logic              mode;
  logic [CNT_W-1:0]  data_in;
  logic [CNT_W-1:0]  count_in;
  logic              checking;
  logic              mismatch;
  logic              range_err;
  logic              err_sticky;
  logic [ERR_W-1:0]  error_cnt;
  logic [WRAP_W-1:0] wrap_cnt;
  logic [CNT_W-1:0]  first_exp;
  logic [CNT_W-1:0]  first_act;
  logic [1:0]        state_dbg;

  mod12_count_checker #(
    .CNT_W(CNT_W), .MOD(MOD), .ERR_W(ERR_W), .WRAP_W(WRAP_W)
  ) dut (
    .clock(clock), .reset(reset), .obs_en(obs_en), .load(load), .mode(mode),
    .data_in(data_in), .count_in(count_in), .checking(checking),
    .mismatch(mismatch), .range_err(range_err), .err_sticky(err_sticky),
    .error_cnt(error_cnt), .wrap_cnt(wrap_cnt), .first_exp(first_exp),
    .first_act(first_act), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic              checking;
    logic              mismatch;
    logic              range_err;
    logic              err_sticky;
    logic [ERR_W-1:0]  error_cnt;
    logic [WRAP_W-1:0] wrap_cnt;
    logic [CNT_W-1:0]  first_exp;
    logic [CNT_W-1:0]  first_act;
    logic [1:0]        state;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check_field(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model tracks the observation phase, the previous sample and the
  // controls that accompanied it, and derives expectations with modular
  // arithmetic on plain integers.
  int m_phase, m_prev, m_ld, m_md, m_din;
  int m_chk, m_mis, m_rng, m_sticky, m_err, m_wrap, m_fexp, m_fact;

  task automatic model_fail(input int exp_v, input int act_v);
    if (m_sticky == 0) begin
      m_fexp = exp_v;
      m_fact = act_v;
    end
    m_sticky = 1;
    if (m_err < ERR_MAX) m_err++;
  endtask

  task automatic model_step(input int rst, input int en, input int ld,
                            input int md, input int din, input int cin);
    int exp_v;
    m_mis = 0;
    m_rng = 0;
    if (rst != 0) begin
      m_phase = P_IDLE; m_prev = 0; m_ld = 0; m_md = 0; m_din = 0;
      m_sticky = 0; m_err = 0; m_wrap = 0; m_fexp = 0; m_fact = 0;
    end else if (en == 0) begin
      m_phase = P_IDLE;
    end else if (m_phase == P_IDLE) begin
      m_phase = P_SYNC;
    end else if (m_phase == P_SYNC) begin
      if (cin >= MOD) begin
        m_rng = 1;
        m_sticky = 1;
      end else begin
        m_phase = P_CHECK;
      end
      m_prev = cin; m_ld = ld; m_md = md; m_din = din;
    end else begin
      if (m_ld != 0 && m_din >= MOD) begin
        m_phase = P_SYNC;
      end else begin
        if (m_ld != 0)      exp_v = m_din;
        else if (m_md != 0) exp_v = (m_prev + 1) % MOD;
        else                exp_v = (m_prev + MOD - 1) % MOD;
        if (cin >= MOD) begin
          m_rng = 1;
          model_fail(exp_v, cin);
          m_phase = P_SYNC;
        end else if (cin != exp_v) begin
          m_mis = 1;
          model_fail(exp_v, cin);
        end else if (m_ld == 0 && ((m_md != 0 && cin < m_prev) ||
                                   (m_md == 0 && cin > m_prev))) begin
          if (m_wrap < WRAP_MAX) m_wrap++;
        end
      end
      m_prev = cin; m_ld = ld; m_md = md; m_din = din;
    end
    m_chk = (m_phase == P_CHECK) ? 1 : 0;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.checking   = (m_chk != 0);
    e.mismatch   = (m_mis != 0);
    e.range_err  = (m_rng != 0);
    e.err_sticky = (m_sticky != 0);
    e.error_cnt  = ERR_W'(m_err);
    e.wrap_cnt   = WRAP_W'(m_wrap);
    e.first_exp  = CNT_W'(m_fexp);
    e.first_act  = CNT_W'(m_fact);
    e.state      = 2'(m_phase);
    return e;
  endfunction

  // ---------------- driver ----------------
  // ctr is a correct mod-MOD counter; a glitch replaces the observed value
  // and, when legal, the counter carries on from it.
  int ctr = 0;

  task automatic drive(input int rst, input int en, input int ld, input int md,
                       input int din, input int glitch, input int gval);
    int cin, base;
    cin = (glitch != 0) ? gval : ctr;
    @(negedge clock);
    reset = (rst != 0); obs_en = (en != 0); load = (ld != 0); mode = (md != 0);
    data_in = din[CNT_W-1:0]; count_in = cin[CNT_W-1:0];
    model_step(rst, en, ld, md, din, cin);
    exp_q.push_back(model_out());
    base = (glitch != 0 && gval < MOD) ? gval : ctr;
    if (rst != 0)      ctr = 0;
    else if (ld != 0)  ctr = din % MOD;
    else if (md != 0)  ctr = (base + 1) % MOD;
    else               ctr = (base + MOD - 1) % MOD;
  endtask

  task automatic settle();
    @(posedge clock);
    #2;
  endtask

  // ---------------- monitor ----------------
  exp_t e_mon;
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e_mon = exp_q.pop_front();
        check_field("checking",   int'(checking),   int'(e_mon.checking));
        check_field("mismatch",   int'(mismatch),   int'(e_mon.mismatch));
        check_field("range_err",  int'(range_err),  int'(e_mon.range_err));
        check_field("err_sticky", int'(err_sticky), int'(e_mon.err_sticky));
        check_field("error_cnt",  int'(error_cnt),  int'(e_mon.error_cnt));
        check_field("wrap_cnt",   int'(wrap_cnt),   int'(e_mon.wrap_cnt));
        check_field("first_exp",  int'(first_exp),  int'(e_mon.first_exp));
        check_field("first_act",  int'(first_act),  int'(e_mon.first_act));
        check_field("state",      int'(state_dbg),  int'(e_mon.state));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; obs_en = 1'b0; load = 1'b0; mode = 1'b0;
    data_in = '0; count_in = '0;

    // Load 5, then up-count through the 11->0 wrap.
    drive(1, 0, 0, 0, 0, 0, 0);
    settle();
    check_field("reset_err", int'(error_cnt), 0);
    check_field("reset_state", int'(state_dbg), P_IDLE);
    drive(0, 1, 1, 1, 5, 0, 0);
    for (int i = 0; i < 10; i++) drive(0, 1, 0, 1, 0, 0, 0);
    settle();
    check_field("up_wrap", int'(wrap_cnt), 1);
    check_field("up_err", int'(error_cnt), 0);
    check_field("up_sticky", int'(err_sticky), 0);
    check_field("up_checking", int'(checking), 1);

    // Load 2, then down-count through the 0->11 wrap.
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 2, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 0, 0, 0);
    settle();
    check_field("down_wrap", int'(wrap_cnt), 1);
    check_field("down_err", int'(error_cnt), 0);

    // Single glitch: 7 observed where 4 is expected.
    drive(0, 1, 1, 1, 3, 0, 0);
    drive(0, 1, 0, 1, 0, 0, 0);
    drive(0, 1, 0, 1, 0, 1, 7);
    settle();
    check_field("glitch_pulse", int'(mismatch), 1);
    check_field("glitch_err", int'(error_cnt), 1);
    check_field("glitch_fexp", int'(first_exp), 4);
    check_field("glitch_fact", int'(first_act), 7);
    check_field("glitch_sticky", int'(err_sticky), 1);
    drive(0, 1, 0, 1, 0, 0, 0);
    settle();
    check_field("after_glitch_pulse", int'(mismatch), 0);
    check_field("after_glitch_err", int'(error_cnt), 1);

    // Out-of-range sample in CHECK, then resume.
    drive(0, 1, 0, 1, 0, 1, 13);
    settle();
    check_field("range_pulse", int'(range_err), 1);
    check_field("range_err_cnt", int'(error_cnt), 2);
    check_field("range_state", int'(state_dbg), P_SYNC);
    drive(0, 1, 0, 1, 0, 0, 0);
    settle();
    check_field("resume_state", int'(state_dbg), P_CHECK);
    check_field("resume_err", int'(error_cnt), 2);

    // Illegal load value: next sample skipped, resync.
    drive(0, 1, 1, 1, 14, 0, 0);
    drive(0, 1, 0, 1, 0, 0, 0);
    settle();
    check_field("illegal_state", int'(state_dbg), P_SYNC);
    check_field("illegal_err", int'(error_cnt), 2);

    // 300 mismatches saturate the error counter.
    drive(0, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 300; i++) drive(0, 1, 0, 1, 0, 1, (ctr + 5) % MOD);
    settle();
    check_field("sat_err", int'(error_cnt), ERR_MAX);

    // Reset mid-stream clears everything.
    drive(1, 1, 0, 1, 0, 1, (ctr + 5) % MOD);
    settle();
    check_field("midrst_err", int'(error_cnt), 0);
    check_field("midrst_sticky", int'(err_sticky), 0);
    check_field("midrst_state", int'(state_dbg), P_IDLE);
    check_field("midrst_fact", int'(first_act), 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      int rst, en, ld, md, din, gl, gv;
      rst = ($urandom_range(0, 199) == 0) ? 1 : 0;
      en  = ($urandom_range(0, 19) == 0) ? 0 : 1;
      ld  = ($urandom_range(0, 6) == 0) ? 1 : 0;
      md  = int'($urandom_range(0, 1));
      din = int'($urandom_range(0, 15));
      gl  = ($urandom_range(0, 19) == 0) ? 1 : 0;
      gv  = int'($urandom_range(0, 15));
      drive(rst, en, ld, md, din, gl, gv);
    end

    repeat (3) @(posedge clock);
    #2;
    check_field("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
